// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multicycle EX-stage ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'h0;
  localparam logic [3:0] ALU_OR    = 4'h1;
  localparam logic [3:0] ALU_NOR   = 4'h2;
  localparam logic [3:0] ALU_ADD   = 4'h3;
  localparam logic [3:0] ALU_SUB   = 4'h4;
  localparam logic [3:0] ALU_LUI   = 4'h5;
  localparam logic [3:0] ALU_JAL   = 4'h6;
  localparam logic [3:0] ALU_SLL   = 4'h7;
  localparam logic [3:0] ALU_SRL   = 4'h8;
  localparam logic [3:0] ALU_SLT   = 4'h9;
  localparam logic [3:0] ALU_MULTU = 4'hA;
  localparam logic [3:0] ALU_DIVU  = 4'hB;
  localparam logic [3:0] ALU_MFHI  = 4'hC;
  localparam logic [3:0] ALU_MFLO  = 4'hD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle, WIDTH cycles.
// Loads on go; done is high during the last iteration, with hi/lo carrying that iteration's result.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // rem_q is the product high half / partial remainder; acc_q the multiplier / dividend-quotient.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opd_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   lhs, rhs, sum, step;

  always_comb begin
    lhs   = div_q ? {rem_q, acc_q[WIDTH-1]} : {1'b0, rem_q};
    rhs   = {1'b0, opd_q};
    sum   = div_q ? (lhs - rhs) : (lhs + rhs);
    step  = '0;
    rem_d = rem_q;
    acc_d = acc_q;
    if (div_q) begin
      // A borrow out of the shared subtractor means the divisor did not fit: restore.
      rem_d = sum[WIDTH] ? lhs[WIDTH-1:0] : sum[WIDTH-1:0];
      acc_d = {acc_q[WIDTH-2:0], ~sum[WIDTH]};
    end else begin
      step  = acc_q[0] ? sum : {1'b0, rem_q};
      rem_d = step[WIDTH:1];
      acc_d = {step[0], acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (go) begin
      rem_q <= '0;
      acc_q <= is_div ? a : b;
      opd_q <= is_div ? b : a;
      div_q <= is_div;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      rem_q <= rem_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign hi   = rem_d;
  assign lo   = acc_d;

endmodule

// File: rtl/alu_multicycle_unit.sv
// EX-stage ALU: single-cycle ops in 1 cycle, MULTU/DIVU in WIDTH+1 cycles writing HI/LO.
// busy_o stalls the pipeline; start_i while busy is dropped, never queued.
module alu_multicycle_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sc_res;
  logic             go;
  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  md_iter_core #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .is_div (ALUOperation == ALU_DIVU),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_comb begin
    sc_res = '0;
    case (ALUOperation)
      ALU_AND:  sc_res = A & B;
      ALU_OR:   sc_res = A | B;
      ALU_NOR:  sc_res = ~(A | B);
      ALU_ADD:  sc_res = A + B;
      ALU_SUB:  sc_res = A - B;
      ALU_LUI:  sc_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_JAL:  sc_res = B;
      ALU_SLL:  sc_res = B << shamt;
      ALU_SRL:  sc_res = B >> shamt;
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_MFHI: sc_res = hi_q;
      ALU_MFLO: sc_res = lo_q;
      default:  sc_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (is_iter(ALUOperation)) begin
            go      = 1'b1;
            state_d = ST_RUN;
          end else begin
            res_d   = sc_res;
            zero_d  = (sc_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (md_done) begin
          hi_d    = md_hi;
          lo_d    = md_lo;
          res_d   = md_lo;
          zero_d  = (md_lo == '0);
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o    = (state_q == ST_RUN);
  assign valid_o   = valid_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

endmodule
